// File: rtl/fp_pkg.sv
// Shared fp32 definitions: field widths, int32 limits, converter FSM states and
// the operand classes produced by fp_classify.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
  // -2^31 as fp32: the only exponent-158 operand that still fits in int32
  localparam logic [31:0] FP32_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } round_mode_t;

  typedef enum logic [2:0] {
    CLS_SPECIAL,
    CLS_ZERO,
    CLS_OVF,
    CLS_RIGHT,
    CLS_LEFT
  } fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/fp_to_int_conv_if.sv
// Operand/result channel of the fp32 -> int32 converter.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both
// high; the source holds its payload stable while valid is high and ready is low.
interface fp_to_int_conv_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        invalid;
  logic        overflow;
  logic        inexact;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, Result, invalid, overflow, inexact
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, Result, invalid, overflow, inexact
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational decode of a packed fp32 operand into its conversion class, the
// shift amount for the iterative shifter, and the final word for special classes.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] a,
  output fp_class_t   cls,
  output logic [4:0]  shamt,
  output logic [31:0] specResult,
  output logic        specInvalid,
  output logic        specOverflow,
  output logic        specInexact
);

  fp32_t f;
  assign f = a;

  always_comb begin
    cls          = CLS_ZERO;
    shamt        = '0;
    specResult   = '0;
    specInvalid  = 1'b0;
    specOverflow = 1'b0;
    specInexact  = 1'b0;
    if (f.exponent == 8'hFF) begin
      cls         = CLS_SPECIAL;
      specInvalid = 1'b1;
      specResult  = ((f.mantissa != '0) || !f.sign) ? INT32_MAX : INT32_MIN;
    end else if (f.exponent < 8'(BIAS - 1)) begin
      // |value| < 0.5: truncates and rounds to zero in every mode
      cls         = CLS_ZERO;
      specInexact = |a[30:0];
    end else if (f.exponent >= 8'(BIAS + 31)) begin
      cls = CLS_OVF;
      if (a == FP32_NEG_2P31) begin
        specResult = INT32_MIN;
      end else begin
        specResult   = f.sign ? INT32_MIN : INT32_MAX;
        specOverflow = 1'b1;
      end
    end else if (f.exponent <= 8'(BIAS + 22)) begin
      cls   = CLS_RIGHT;
      shamt = 5'(8'(BIAS + 23) - f.exponent);
    end else begin
      cls   = CLS_LEFT;
      shamt = 5'(f.exponent - 8'(BIAS + 23));
    end
  end

endmodule

// File: rtl/fp_to_int_conv.sv
// Sequential fp32 -> int32 converter: classify on accept, denormalize with an
// iterative shifter of up to SHIFT_STEP bits per cycle, then round and negate.
module fp_to_int_conv
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int ROUND_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_to_int_conv_if.slave    bus,
  output state_t             dbgState
);

  state_t      state, nextState;
  fp_class_t   cls;
  logic [4:0]  shamt;
  logic [31:0] specResult;
  logic        specInvalid, specOverflow, specInexact;

  logic [31:0] mag, shiftedMag, lowMask, roundedMag;
  logic        guardBit, stickyBit, nextGuard, nextSticky;
  logic [4:0]  remaining, stepK, stepKm1;
  logic        shiftLeft, signReg, roundUp;
  logic [31:0] resultReg;
  logic        invalidReg, overflowReg, inexactReg;
  logic        inReady, outValid;

  fp_classify u_classify (
    .a            (bus.A),
    .cls          (cls),
    .shamt        (shamt),
    .specResult   (specResult),
    .specInvalid  (specInvalid),
    .specOverflow (specOverflow),
    .specInexact  (specInexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          if (cls == CLS_RIGHT || cls == CLS_LEFT) nextState = (shamt == '0) ? ROUND : SHIFT;
          else                                     nextState = DONE;
        end
      end
      SHIFT:   if (remaining == stepK) nextState = ROUND;
      ROUND:   nextState = DONE;
      DONE: begin
        outValid = 1'b1;
        if (bus.out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    stepK      = (remaining > 5'(SHIFT_STEP)) ? 5'(SHIFT_STEP) : remaining;
    stepKm1    = stepK - 5'd1;
    lowMask    = (32'd1 << stepKm1) - 32'd1;
    shiftedMag = mag;
    nextGuard  = guardBit;
    nextSticky = stickyBit;
    if (shiftLeft) begin
      shiftedMag = mag << stepK;
    end else if (stepK != '0) begin
      // The old guard falls behind the new one, so it joins the sticky bit
      shiftedMag = mag >> stepK;
      nextGuard  = mag[stepKm1];
      nextSticky = stickyBit | guardBit | (|(mag & lowMask));
    end
  end

  always_comb begin
    roundUp    = (ROUND_MODE == int'(RND_RNE)) && guardBit && (stickyBit || mag[0]);
    roundedMag = mag + 32'(roundUp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag         <= '0;
      guardBit    <= 1'b0;
      stickyBit   <= 1'b0;
      remaining   <= '0;
      shiftLeft   <= 1'b0;
      signReg     <= 1'b0;
      resultReg   <= '0;
      invalidReg  <= 1'b0;
      overflowReg <= 1'b0;
      inexactReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mag       <= {8'b0, 1'b1, bus.A[22:0]};
          guardBit  <= 1'b0;
          stickyBit <= 1'b0;
          remaining <= shamt;
          shiftLeft <= (cls == CLS_LEFT);
          signReg   <= bus.A[31];
          if (cls != CLS_RIGHT && cls != CLS_LEFT) begin
            resultReg   <= specResult;
            invalidReg  <= specInvalid;
            overflowReg <= specOverflow;
            inexactReg  <= specInexact;
          end
        end
        SHIFT: begin
          mag       <= shiftedMag;
          guardBit  <= nextGuard;
          stickyBit <= nextSticky;
          remaining <= remaining - stepK;
        end
        ROUND: begin
          resultReg   <= signReg ? (-roundedMag) : roundedMag;
          invalidReg  <= 1'b0;
          overflowReg <= 1'b0;
          inexactReg  <= guardBit | stickyBit;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.Result    = resultReg;
  assign bus.invalid   = invalidReg;
  assign bus.overflow  = overflowReg;
  assign bus.inexact   = inexactReg;
  assign dbgState      = state;

endmodule
